// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard receiver.
// Holds the prefix bytes, the reserved (non-key) codes, a few navigation
// key codes, and the frame FSM state encoding.
package ps2_pkg;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;

  // Navigation keys used by the display controller
  localparam logic [7:0] PS2_KEY_LEFT  = 8'h6B;
  localparam logic [7:0] PS2_KEY_RIGHT = 8'h74;
  localparam logic [7:0] PS2_KEY_UP    = 8'h75;
  localparam logic [7:0] PS2_KEY_DOWN  = 8'h72;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } frame_state_e;

  // Keyboard status/response bytes that never represent a key
  function automatic logic ps2_is_reserved(input logic [7:0] code);
    case (code)
      8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: return 1'b1;
      default:                                  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronises both raw lines, de-glitches the clock,
// and deserialises 11-bit frames (start, 8 data LSB-first, odd parity, stop).
// Ports:
//   iVGA_CLK, iRST_n     clock, async active-low reset
//   ps2_clk, ps2_data    raw asynchronous PS/2 lines (input only)
//   byte_data[7:0]       assembled data byte, valid while byte_valid_c is high
//   byte_valid_c         combinational, high in the stop-bit event cycle of a good frame
//   byte_err_c           combinational, high on bad parity/stop or mid-frame timeout
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       iVGA_CLK,
  input  logic       iRST_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] byte_data,
  output logic       byte_valid_c,
  output logic       byte_err_c
);

  localparam int unsigned FW    = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic clk_s1, clk_s2, data_s1, data_s2;
  logic clk_filt;
  logic [FW-1:0] filt_cnt;
  logic bit_evt;

  frame_state_e state, state_n;
  logic [2:0]       bit_cnt, bit_cnt_n;
  logic [7:0]       shreg, shreg_n;
  logic             parity, parity_n;
  logic [TMO_W-1:0] tmo_cnt, tmo_n, tmo_inc;
  logic             tmo_hit, frame_ok;

  // Two-flop synchronisers; lines idle high
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
    end else begin
      clk_s1  <= ps2_clk;
      clk_s2  <= clk_s1;
      data_s1 <= ps2_data;
      data_s2 <= data_s1;
    end
  end

  // Clock filter: level flips on the FILTER_LEN-th consecutive differing sample
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      clk_filt <= 1'b1;
      filt_cnt <= '0;
    end else if (clk_s2 != clk_filt) begin
      if (filt_cnt == FW'(FILTER_LEN - 1)) begin
        clk_filt <= clk_s2;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + FW'(1);
      end
    end else begin
      filt_cnt <= '0;
    end
  end

  // Bit event: the cycle in which the filtered clock falls
  assign bit_evt = clk_filt && !clk_s2 && (filt_cnt == FW'(FILTER_LEN - 1));

  assign tmo_inc  = tmo_cnt + TMO_W'(1);
  assign tmo_hit  = (state != IDLE) && !bit_evt && (tmo_inc == TMO_W'(TIMEOUT_CYCLES));
  assign frame_ok = data_s2 && (^{shreg, parity});
  assign byte_data = shreg;

  // Frame state register
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      parity  <= 1'b0;
      tmo_cnt <= '0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      shreg   <= shreg_n;
      parity  <= parity_n;
      tmo_cnt <= tmo_n;
    end
  end

  // Frame next-state and strobes
  always_comb begin
    state_n      = state;
    bit_cnt_n    = bit_cnt;
    shreg_n      = shreg;
    parity_n     = parity;
    tmo_n        = '0;
    byte_valid_c = 1'b0;
    byte_err_c   = 1'b0;

    if (state != IDLE) tmo_n = bit_evt ? '0 : tmo_inc;

    case (state)
      IDLE: begin
        if (bit_evt && !data_s2) begin
          state_n   = DATA;
          bit_cnt_n = '0;
          shreg_n   = '0;
        end
      end
      DATA: begin
        if (bit_evt) begin
          shreg_n   = {data_s2, shreg[7:1]};
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_n = PARITY;
        end
      end
      PARITY: begin
        if (bit_evt) begin
          parity_n = data_s2;
          state_n  = STOP;
        end
      end
      STOP: begin
        if (bit_evt) begin
          state_n = IDLE;
          if (frame_ok) byte_valid_c = 1'b1;
          else          byte_err_c   = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // Stalled frame: abort and report
    if (tmo_hit) begin
      state_n    = IDLE;
      tmo_n      = '0;
      byte_err_c = 1'b1;
    end
  end

endmodule

// File: rtl/ps2_scan_decoder.sv
// PS/2 keyboard scan-code decoder feeding the VGA display controller.
// Resolves E0/F0 prefixes on bytes from ps2_frame_rx and emits one strobe
// per make or break event. Receive-only.
// Ports:
//   iVGA_CLK, iRST_n   clock, async active-low reset
//   ps2_clk, ps2_data  raw PS/2 lines
//   ps2_out[7:0]       last decoded scan code, held
//   ps2_key_pressed    1-cycle make strobe
//   ps2_key_released   1-cycle break strobe
//   ps2_extended       event carried E0, valid with strobes and held
//   frame_err          1-cycle strobe on parity/stop/timeout error
// Build option: PS2_TYPEMATIC_FILTER_EN suppresses auto-repeat makes of the held key.
module ps2_scan_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       iVGA_CLK,
  input  logic       iRST_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] ps2_out,
  output logic       ps2_key_pressed,
  output logic       ps2_key_released,
  output logic       ps2_extended,
  output logic       frame_err
);

  logic [7:0] byte_data;
  logic       byte_valid_c, byte_err_c;
  logic       ext_flag, brk_flag;
  logic       key_evt_c, repeat_c;

  ps2_frame_rx #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .iVGA_CLK    (iVGA_CLK),
    .iRST_n      (iRST_n),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .byte_data   (byte_data),
    .byte_valid_c(byte_valid_c),
    .byte_err_c  (byte_err_c)
  );

  // A byte that names a key (not a prefix, not a status code)
  assign key_evt_c = byte_valid_c && (byte_data != PS2_PREFIX_EXT)
                     && (byte_data != PS2_PREFIX_BRK) && !ps2_is_reserved(byte_data);

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic [8:0] evt_key, held_key;
  logic       held;

  assign evt_key  = {ext_flag, byte_data};
  assign repeat_c = held && (held_key == evt_key) && !brk_flag;

  // Track the last key made; its break releases it
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      held     <= 1'b0;
      held_key <= '0;
    end else if (key_evt_c) begin
      if (!brk_flag) begin
        held     <= 1'b1;
        held_key <= evt_key;
      end else if (held_key == evt_key) begin
        held <= 1'b0;
      end
    end
  end
`else
  assign repeat_c = 1'b0;
`endif

  // Prefix tracking and event strobes
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      ps2_out          <= '0;
      ps2_key_pressed  <= 1'b0;
      ps2_key_released <= 1'b0;
      ps2_extended     <= 1'b0;
      frame_err        <= 1'b0;
      ext_flag         <= 1'b0;
      brk_flag         <= 1'b0;
    end else begin
      ps2_key_pressed  <= 1'b0;
      ps2_key_released <= 1'b0;
      frame_err        <= 1'b0;
      if (byte_err_c) begin
        frame_err <= 1'b1;
        ext_flag  <= 1'b0;
        brk_flag  <= 1'b0;
      end else if (byte_valid_c) begin
        if (byte_data == PS2_PREFIX_EXT) begin
          ext_flag <= 1'b1;
        end else if (byte_data == PS2_PREFIX_BRK) begin
          brk_flag <= 1'b1;
        end else begin
          ext_flag <= 1'b0;
          brk_flag <= 1'b0;
          if (key_evt_c && !repeat_c) begin
            ps2_out          <= byte_data;
            ps2_extended     <= ext_flag;
            ps2_key_released <= brk_flag;
            ps2_key_pressed  <= !brk_flag;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Scoreboard bench for ps2_scan_decoder: stimulus queues expected events,
// a monitor pops and compares them on every strobe.
module tb_ps2_scan_decoder;
  import ps2_pkg::*;

  localparam int unsigned FL   = 8;
  localparam int unsigned TMO  = 400;
  localparam int          HALF = 20;
  localparam int          GAP  = 80;

  localparam int K_PRESS = 0;
  localparam int K_REL   = 1;
  localparam int K_ERR   = 2;

  typedef struct {
    int         kind;
    logic [7:0] code;
    logic       ext;
    longint     cyc;   // 0 = arrival time not checked
  } evt_t;

  logic clk, rst_n, ps2_clk, ps2_data;
  logic [7:0] ps2_out;
  logic pressed, released, extended, ferr;

  evt_t   exp_q[$];
  int     n_checks = 0;
  int     n_fail   = 0;
  longint cyc      = 0;
  logic [7:0] last_code = 8'h00;
  logic       last_ext  = 1'b0;

  ps2_scan_decoder #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TMO)) dut (
    .iVGA_CLK        (clk),
    .iRST_n          (rst_n),
    .ps2_clk         (ps2_clk),
    .ps2_data        (ps2_data),
    .ps2_out         (ps2_out),
    .ps2_key_pressed (pressed),
    .ps2_key_released(released),
    .ps2_extended    (extended),
    .frame_err       (ferr)
  );

  initial begin
    clk = 1'b0;
    forever #20 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic logic [10:0] frame_bits(input logic [7:0] code, input logic bad_par);
    return {1'b1, (~^code) ^ bad_par, code, 1'b0};
  endfunction

  task automatic drive_bits(input logic [10:0] bits, input int nbits, output longint last_fall);
    last_fall = 0;
    for (int i = 0; i < nbits; i++) begin
      ps2_data = bits[i];
      repeat (HALF) @(negedge clk);
      ps2_clk   = 1'b0;
      last_fall = cyc;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
    repeat (HALF) @(negedge clk);
    ps2_data = 1'b1;
  endtask

  task automatic send(input logic [7:0] code, input logic bad_par);
    longint lf;
    drive_bits(frame_bits(code, bad_par), 11, lf);
    repeat (GAP) @(negedge clk);
  endtask

  task automatic exp_key(input int kind, input logic [7:0] code, input logic ext);
    evt_t e;
    e.kind = kind; e.code = code; e.ext = ext; e.cyc = 0;
    exp_q.push_back(e);
    last_code = code;
    last_ext  = ext;
  endtask

  task automatic exp_err(input longint at);
    evt_t e;
    e.kind = K_ERR; e.code = last_code; e.ext = last_ext; e.cyc = at;
    exp_q.push_back(e);
  endtask

  // Monitor: every strobe must match the head of the expectation queue
  initial begin
    evt_t e;
    int   n;
    int   act_kind;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        n = int'(pressed) + int'(released) + int'(ferr);
        if (n > 1) begin
          check("strobe_exclusive", n, 1);
        end else if (n == 1) begin
          if (exp_q.size() == 0) begin
            check("unexpected_strobe", {pressed, released, ferr}, 0);
          end else begin
            e = exp_q.pop_front();
            act_kind = pressed ? K_PRESS : (released ? K_REL : K_ERR);
            check("event_kind", act_kind, e.kind);
            check("ps2_out", ps2_out, e.code);
            check("ps2_extended", extended, e.ext);
            if (e.cyc != 0) check("err_timing", cyc, e.cyc);
          end
        end
      end
    end
  end

  initial begin
    longint lf;
    int     waited;
    rst_n    = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_out", ps2_out, 0);
    check("rst_strobes", {pressed, released, extended, ferr}, 0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // Plain make
    exp_key(K_PRESS, PS2_KEY_UP, 1'b0);
    send(PS2_KEY_UP, 1'b0);

    // Reserved code dropped and clears the pending E0
    send(PS2_PREFIX_EXT, 1'b0);
    send(8'hAA, 1'b0);
    exp_key(K_PRESS, 8'h1C, 1'b0);
    send(8'h1C, 1'b0);

    // Extended break, both prefix orders
    send(PS2_PREFIX_EXT, 1'b0);
    send(PS2_PREFIX_BRK, 1'b0);
    exp_key(K_REL, PS2_KEY_UP, 1'b1);
    send(PS2_KEY_UP, 1'b0);
    send(PS2_PREFIX_BRK, 1'b0);
    send(PS2_PREFIX_EXT, 1'b0);
    send(PS2_PREFIX_EXT, 1'b0);
    exp_key(K_REL, PS2_KEY_UP, 1'b1);
    send(PS2_KEY_UP, 1'b0);

    // Bad parity, then a good frame of the same key
    exp_err(0);
    send(PS2_KEY_LEFT, 1'b1);
    exp_key(K_PRESS, PS2_KEY_LEFT, 1'b0);
    send(PS2_KEY_LEFT, 1'b0);

    // Timeout: start + 5 data bits. The filtered edge registers 2 sync +
    // FL filter posedges after the raw edge; frame_err follows TMO later.
    drive_bits(frame_bits(PS2_KEY_DOWN, 1'b0), 6, lf);
    exp_err(lf + 2 + FL + TMO);
    repeat (TMO + 60) @(negedge clk);
    exp_key(K_PRESS, PS2_KEY_DOWN, 1'b0);
    send(PS2_KEY_DOWN, 1'b0);

    // 3-cycle clock glitch with data low must not start a frame
    ps2_data = 1'b0;
    ps2_clk  = 1'b0;
    repeat (3) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (40) @(negedge clk);
    ps2_data = 1'b1;
    repeat (40) @(negedge clk);
    exp_key(K_PRESS, PS2_KEY_RIGHT, 1'b0);
    send(PS2_KEY_RIGHT, 1'b0);
    send(PS2_PREFIX_BRK, 1'b0);
    exp_key(K_REL, PS2_KEY_RIGHT, 1'b0);
    send(PS2_KEY_RIGHT, 1'b0);

    // Auto-repeat
`ifdef PS2_TYPEMATIC_FILTER_EN
    exp_key(K_PRESS, PS2_KEY_RIGHT, 1'b0);
    for (int i = 0; i < 3; i++) send(PS2_KEY_RIGHT, 1'b0);
`else
    for (int i = 0; i < 3; i++) begin
      exp_key(K_PRESS, PS2_KEY_RIGHT, 1'b0);
      send(PS2_KEY_RIGHT, 1'b0);
    end
`endif
    send(PS2_PREFIX_BRK, 1'b0);
    exp_key(K_REL, PS2_KEY_RIGHT, 1'b0);
    send(PS2_KEY_RIGHT, 1'b0);

    // Reset mid-frame
    drive_bits(frame_bits(PS2_KEY_UP, 1'b0), 5, lf);
    check("pre_rst_out", ps2_out, PS2_KEY_RIGHT);
    rst_n = 1'b0;
    #1;
    check("midrst_out", ps2_out, 0);
    check("midrst_strobes", {pressed, released, extended, ferr}, 0);
    last_code = 8'h00;
    last_ext  = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    exp_key(K_PRESS, PS2_KEY_UP, 1'b0);
    send(PS2_KEY_UP, 1'b0);

    waited = 0;
    while (exp_q.size() != 0 && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    check("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
